// File: rtl/decode_cycle_if.sv
// decode_cycle_if
// Bundles the decode stage's pipeline-facing signals:
//   IF/ID inputs    : InstrD, PCD, PCPlus4D
//   hazard control  : flushE (in), Rs1D/Rs2D (out, combinational)
//   writeback port  : RegWriteW, RDW, ResultW
//   ID/EX outputs   : registered controls, operands and register indices
// modport slave  : the decode stage itself
// modport master : the surrounding pipeline (or a testbench)
interface decode_cycle_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        flushE;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic        ALUSrcAE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic        IllegalE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, flushE, RegWriteW, RDW, ResultW,
    output Rs1D, Rs2D,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
    output ResultSrcE, ALUControlE, funct3E, RD1E, RD2E, ImmExtE,
    output PCE, PCPlus4E, RdE, Rs1E, Rs2E, IllegalE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, flushE, RegWriteW, RDW, ResultW,
    input  Rs1D, Rs2D,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
    input  ResultSrcE, ALUControlE, funct3E, RD1E, RD2E, ImmExtE,
    input  PCE, PCPlus4E, RdE, Rs1E, Rs2E, IllegalE
  );
endinterface

// File: rtl/decode_cycle.sv
// decode_cycle
// RV32I decode stage: control decode, immediate generation, 32x32 register
// file with writeback write port and write-through bypass, and the ID/EX
// pipeline register.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-low reset (clears ID/EX and the register file)
//   bus  : decode_cycle_if.slave (IF/ID inputs, writeback, flush, ID/EX outputs)
module decode_cycle (
  input logic           clk,
  input logic           rst,
  decode_cycle_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1, rs2, rd;

  assign instr    = bus.InstrD;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // One-hot instruction class
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;

  always_comb begin
    is_r      = (opcode == OP_R);
    is_i      = (opcode == OP_I_ALU);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
  end

  // funct3 -> ALU op; alt selects SUB (funct3=0) or SRA (funct3=5)
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, alu_src_a_d;
  logic [1:0] result_src_d;
  logic [3:0] alu_ctrl_d;
  logic       illegal_d;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    alu_src_a_d  = 1'b0;
    result_src_d = 2'b00;
    alu_ctrl_d   = ALU_ADD;
    illegal_d    = 1'b0;
    if (is_r) begin
      reg_write_d = 1'b1;
      alu_ctrl_d  = alu_op(funct3, funct7b5);
    end else if (is_i) begin
      reg_write_d = 1'b1;
      alu_src_d   = 1'b1;
      // instr[30] is an immediate bit for ADDI, so only shifts may see it
      alu_ctrl_d  = alu_op(funct3, (funct3 == 3'd5) && funct7b5);
    end else if (is_load) begin
      reg_write_d  = 1'b1;
      alu_src_d    = 1'b1;
      result_src_d = 2'b01;
    end else if (is_store) begin
      mem_write_d = 1'b1;
      alu_src_d   = 1'b1;
    end else if (is_branch) begin
      branch_d   = 1'b1;
      alu_ctrl_d = ALU_SUB;
    end else if (is_jal) begin
      jump_d       = 1'b1;
      reg_write_d  = 1'b1;
      result_src_d = 2'b10;
    end else if (is_jalr) begin
      jump_d       = 1'b1;
      reg_write_d  = 1'b1;
      alu_src_d    = 1'b1;
      result_src_d = 2'b10;
    end else if (is_lui) begin
      reg_write_d = 1'b1;
      alu_src_d   = 1'b1;
      alu_ctrl_d  = ALU_PASSB;
    end else if (is_auipc) begin
      reg_write_d = 1'b1;
      alu_src_d   = 1'b1;
      alu_src_a_d = 1'b1;
    end else begin
      illegal_d = 1'b1;
    end
  end

  // Immediate generation; R-type and illegal opcodes yield 0
  logic [31:0] imm_d;

  always_comb begin
    imm_d = 32'd0;
    if (is_i || is_load || is_jalr)
      imm_d = {{20{instr[31]}}, instr[31:20]};
    else if (is_store)
      imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_branch)
      imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm_d = {instr[31:12], 12'd0};
    else if (is_jal)
      imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Register file; entry 0 is never written and is masked on read
  logic [31:0] rf [32];
  logic        wb_en;

  assign wb_en = bus.RegWriteW && (bus.RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_en) begin
      rf[bus.RDW] <= bus.ResultW;
    end
  end

  logic [31:0] rd1_d, rd2_d;

  // Write-through: a same-cycle writeback to the read index wins over storage
  always_comb begin
    rd1_d = 32'd0;
    if (rs1 != 5'd0) rd1_d = (wb_en && (bus.RDW == rs1)) ? bus.ResultW : rf[rs1];
  end

  always_comb begin
    rd2_d = 32'd0;
    if (rs2 != 5'd0) rd2_d = (wb_en && (bus.RDW == rs2)) ? bus.ResultW : rf[rs2];
  end

  // ID/EX register. A flush zeroes controls and indices; data still loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ALUSrcAE    <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.ALUControlE <= 4'h0;
      bus.IllegalE    <= 1'b0;
      bus.RdE         <= 5'd0;
      bus.Rs1E        <= 5'd0;
      bus.Rs2E        <= 5'd0;
      bus.funct3E     <= 3'd0;
      bus.RD1E        <= 32'd0;
      bus.RD2E        <= 32'd0;
      bus.ImmExtE     <= 32'd0;
      bus.PCE         <= 32'd0;
      bus.PCPlus4E    <= 32'd0;
    end else begin
      bus.funct3E  <= funct3;
      bus.RD1E     <= rd1_d;
      bus.RD2E     <= rd2_d;
      bus.ImmExtE  <= imm_d;
      bus.PCE      <= bus.PCD;
      bus.PCPlus4E <= bus.PCPlus4D;
      if (bus.flushE) begin
        bus.RegWriteE   <= 1'b0;
        bus.MemWriteE   <= 1'b0;
        bus.JumpE       <= 1'b0;
        bus.BranchE     <= 1'b0;
        bus.ALUSrcE     <= 1'b0;
        bus.ALUSrcAE    <= 1'b0;
        bus.ResultSrcE  <= 2'b00;
        bus.ALUControlE <= 4'h0;
        bus.IllegalE    <= 1'b0;
        bus.RdE         <= 5'd0;
        bus.Rs1E        <= 5'd0;
        bus.Rs2E        <= 5'd0;
      end else begin
        bus.RegWriteE   <= reg_write_d;
        bus.MemWriteE   <= mem_write_d;
        bus.JumpE       <= jump_d;
        bus.BranchE     <= branch_d;
        bus.ALUSrcE     <= alu_src_d;
        bus.ALUSrcAE    <= alu_src_a_d;
        bus.ResultSrcE  <= result_src_d;
        bus.ALUControlE <= alu_ctrl_d;
        bus.IllegalE    <= illegal_d;
        bus.RdE         <= rd;
        bus.Rs1E        <= rs1;
        bus.Rs2E        <= rs2;
      end
    end
  end

endmodule
